// File: rtl/uart_tx_arbiter.sv
// Round-robin burst arbiter sharing one uart_tx byte channel
// between the CPU register port (req 0) and the debug monitor (req 1).
module uart_tx_arbiter #(
  parameter int unsigned MAX_BURST    = 16,
  parameter int unsigned IDLE_TIMEOUT = 1024
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req0_valid,
  input  logic [7:0] req0_data,
  input  logic       req0_last,
  output logic       req0_ready,
  input  logic       req1_valid,
  input  logic [7:0] req1_data,
  input  logic       req1_last,
  output logic       req1_ready,
  output logic [7:0] tx_data,
  output logic       tx_data_valid,
  input  logic       tx_data_ready,
  output logic       grant_active,
  output logic       grant_id
);

  localparam int unsigned BW = $clog2(MAX_BURST + 1);

  typedef enum logic {
    IDLE,
    BURST
  } state_e;

  state_e        state_q, state_d;
  logic          prio_q, prio_d;
  logic          gid_q, gid_d;
  logic [BW-1:0] bcnt_q, bcnt_d;
  logic [15:0]   icnt_q, icnt_d;

  logic       active;
  logic       g_valid;
  logic       g_last;
  logic [7:0] g_data;
  logic       xfer;
  logic       bcnt_hit;
  logic       icnt_hit;
  logic       release_c;

  // Reset gates the datapath at once so no byte is offered while rst is high.
  always_comb begin
    active        = (state_q == BURST) && !rst;
    g_valid       = gid_q ? req1_valid : req0_valid;
    g_last        = gid_q ? req1_last  : req0_last;
    g_data        = gid_q ? req1_data  : req0_data;
    tx_data       = active ? g_data : 8'h00;
    tx_data_valid = active && g_valid;
    req0_ready    = active && !gid_q && tx_data_ready;
    req1_ready    = active &&  gid_q && tx_data_ready;
    xfer          = tx_data_valid && tx_data_ready;
    bcnt_hit      = (32'(bcnt_q) + 32'd1) == MAX_BURST;
    icnt_hit      = (32'(icnt_q) + 32'd1) == IDLE_TIMEOUT;
  end

  assign grant_active = (state_q == BURST);
  assign grant_id     = gid_q;

  always_comb begin
    state_d   = state_q;
    prio_d    = prio_q;
    gid_d     = gid_q;
    bcnt_d    = bcnt_q;
    icnt_d    = icnt_q;
    release_c = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (req0_valid || req1_valid) begin
          state_d = BURST;
          gid_d   = (req0_valid && req1_valid) ? prio_q : req1_valid;
          bcnt_d  = '0;
          icnt_d  = '0;
        end
      end
      BURST: begin
        icnt_d = g_valid ? 16'd0 : icnt_q + 16'd1;
        if (xfer) begin
          bcnt_d = bcnt_q + BW'(1);
        end
        release_c = (xfer && (g_last || bcnt_hit))
                 || (!g_valid && icnt_hit);
        if (release_c) begin
          state_d = IDLE;
          prio_d  = ~gid_q;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      prio_q  <= 1'b0;
      gid_q   <= 1'b0;
      bcnt_q  <= '0;
      icnt_q  <= '0;
    end else begin
      state_q <= state_d;
      prio_q  <= prio_d;
      gid_q   <= gid_d;
      bcnt_q  <= bcnt_d;
      icnt_q  <= icnt_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: requester queues feed the DUT,
// a scoreboard of expected (id, byte) pairs checks every uart_tx transfer.
module tb_uart_tx_arbiter;

  localparam int MB = 16;
  localparam int IT = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic       req0_valid, req0_last, req0_ready;
  logic [7:0] req0_data;
  logic       req1_valid, req1_last, req1_ready;
  logic [7:0] req1_data;
  logic [7:0] tx_data;
  logic       tx_data_valid, tx_data_ready;
  logic       grant_active, grant_id;

  always #5 clk = ~clk;

  uart_tx_arbiter #(
    .MAX_BURST   (MB),
    .IDLE_TIMEOUT(IT)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .req0_valid   (req0_valid),
    .req0_data    (req0_data),
    .req0_last    (req0_last),
    .req0_ready   (req0_ready),
    .req1_valid   (req1_valid),
    .req1_data    (req1_data),
    .req1_last    (req1_last),
    .req1_ready   (req1_ready),
    .tx_data      (tx_data),
    .tx_data_valid(tx_data_valid),
    .tx_data_ready(tx_data_ready),
    .grant_active (grant_active),
    .grant_id     (grant_id)
  );

  typedef struct packed {
    logic [7:0] d;
    logic       l;
  } rb_t;

  typedef struct packed {
    logic       id;
    logic [7:0] d;
  } ex_t;

  rb_t q0[$];
  rb_t q1[$];
  ex_t sb[$];
  ex_t e;

  bit en0  = 1'b1;
  bit en1  = 1'b1;
  bit txr  = 1'b1;
  bit rstv = 1'b1;

  int nchk  = 0;
  int nfail = 0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic p0(input logic [7:0] d, input logic l);
    q0.push_back('{d: d, l: l});
  endtask

  task automatic p1(input logic [7:0] d, input logic l);
    q1.push_back('{d: d, l: l});
  endtask

  task automatic ex(input logic id, input logic [7:0] d);
    sb.push_back('{id: id, d: d});
  endtask

  // One clock: drive after the edge, return after the monitor has sampled.
  task automatic step();
    @(posedge clk);
    #1;
    rst           = rstv;
    tx_data_ready = txr;
    req0_valid    = en0 && (q0.size() > 0);
    req0_data     = (q0.size() > 0) ? q0[0].d : 8'h00;
    req0_last     = (q0.size() > 0) ? q0[0].l : 1'b0;
    req1_valid    = en1 && (q1.size() > 0);
    req1_data     = (q1.size() > 0) ? q1[0].d : 8'h00;
    req1_last     = (q1.size() > 0) ? q1[0].l : 1'b0;
    @(negedge clk);
    #2;
  endtask

  task automatic do_reset();
    rstv = 1'b1;
    step();
    rstv = 1'b0;
    step();
  endtask

  task automatic drain(input string tag, input int budget);
    int n = 0;
    while (sb.size() != 0 && n < budget) begin
      step();
      n++;
    end
    chk({tag, "_drained"}, sb.size(), 0);
    step();
  endtask

  always @(negedge clk) begin
    if (req0_valid && req0_ready) q0.delete(0);
    if (req1_valid && req1_ready) q1.delete(0);
    if (tx_data_valid && tx_data_ready) begin
      if (sb.size() == 0) begin
        chk("sb_unexpected_byte", sb.size(), 1);
      end else begin
        e = sb.pop_front();
        chk("tx_data", {24'd0, tx_data}, {24'd0, e.d});
        chk("tx_gid", {31'd0, grant_id}, {31'd0, e.id});
      end
    end
    chk("rdy0_ungranted",
        req0_ready && !(grant_active && !grant_id), 0);
    chk("rdy1_ungranted",
        req1_ready && !(grant_active && grant_id), 0);
  end

  initial begin
    rst           = 1'b1;
    tx_data_ready = 1'b1;
    req0_valid    = 1'b0;
    req0_data     = 8'h00;
    req0_last     = 1'b0;
    req1_valid    = 1'b0;
    req1_data     = 8'h00;
    req1_last     = 1'b0;

    step();
    step();
    chk("rst_ga", grant_active, 0);
    chk("rst_gid", grant_id, 0);
    chk("rst_txv", tx_data_valid, 0);
    chk("rst_txd", tx_data, 0);
    chk("rst_rdy", {req1_ready, req0_ready}, 0);
    rstv = 1'b0;
    step();
    chk("post_rst_ga", grant_active, 0);

    // single requester, three-byte message
    p0(8'h41, 1'b0); p0(8'h42, 1'b0); p0(8'h43, 1'b1);
    ex(1'b0, 8'h41); ex(1'b0, 8'h42); ex(1'b0, 8'h43);
    step();
    chk("t1_req_cycle_ga", grant_active, 0);
    chk("t1_req_cycle_txv", tx_data_valid, 0);
    step();
    chk("t1_grant_ga", grant_active, 1);
    chk("t1_grant_gid", grant_id, 0);
    chk("t1_first_byte", tx_data, 8'h41);
    step();
    step();
    step();
    chk("t1_idle_after", grant_active, 0);
    chk("t1_sb_empty", sb.size(), 0);

    // priority now req1: both valid together
    p1(8'h55, 1'b1);
    p0(8'h66, 1'b1);
    ex(1'b1, 8'h55); ex(1'b0, 8'h66);
    drain("prio1", 40);
    chk("prio1_idle", grant_active, 0);

    // both valid from reset: req0 wins
    do_reset();
    p0(8'h10, 1'b0); p0(8'h11, 1'b1);
    p1(8'h20, 1'b0); p1(8'h21, 1'b1);
    ex(1'b0, 8'h10); ex(1'b0, 8'h11);
    ex(1'b1, 8'h20); ex(1'b1, 8'h21);
    drain("t2", 40);
    chk("t2_idle", grant_active, 0);

    // req1 streams 20 bytes, forced release at MAX_BURST
    do_reset();
    en0 = 1'b0;
    for (int i = 0; i < 20; i++) p1(8'(8'h80 + i), 1'b0);
    p0(8'hA0, 1'b0); p0(8'hA1, 1'b1);
    for (int i = 0; i < 16; i++) ex(1'b1, 8'(8'h80 + i));
    ex(1'b0, 8'hA0); ex(1'b0, 8'hA1);
    for (int i = 16; i < 20; i++) ex(1'b1, 8'(8'h80 + i));
    step();
    step();
    chk("t3_req1_granted", {grant_active, grant_id}, 2'b11);
    en0 = 1'b1;
    drain("t3", 200);
    repeat (IT + 2) step();
    chk("t3_timeout_idle", grant_active, 0);

    // idle timeout after req0 drops valid
    do_reset();
    p0(8'h33, 1'b0);
    ex(1'b0, 8'h33); ex(1'b1, 8'h44);
    step();
    step();
    chk("t4_byte_taken", q0.size(), 0);
    chk("t4_ga", grant_active, 1);
    p1(8'h44, 1'b1);
    repeat (IT) step();
    chk("t4_hold", grant_active, 1);
    step();
    chk("t4_release", grant_active, 0);
    step();
    chk("t4_req1_grant", {grant_active, grant_id}, 2'b11);
    drain("t4", 20);
    chk("t4_idle", grant_active, 0);

    // uart_tx stalls longer than the idle timeout
    do_reset();
    p0(8'h51, 1'b0); p0(8'h52, 1'b0); p0(8'h53, 1'b1);
    ex(1'b0, 8'h51); ex(1'b0, 8'h52); ex(1'b0, 8'h53);
    step();
    step();
    txr = 1'b0;
    for (int i = 0; i < 12; i++) begin
      step();
      chk("t5_stall_data", tx_data, 8'h52);
      chk("t5_stall_valid", tx_data_valid, 1);
      chk("t5_stall_ga", grant_active, 1);
    end
    txr = 1'b1;
    drain("t5", 20);
    chk("t5_idle", grant_active, 0);

    // reset mid-burst, prio back to req0
    txr = 1'b0;
    p0(8'h61, 1'b0); p0(8'h62, 1'b1);
    ex(1'b0, 8'h61); ex(1'b0, 8'h62); ex(1'b1, 8'h71);
    step();
    step();
    chk("t6_burst", {grant_active, grant_id}, 2'b10);
    p1(8'h71, 1'b1);
    step();
    rstv = 1'b1;
    step();
    chk("t6_in_rst_txv", tx_data_valid, 0);
    chk("t6_in_rst_txd", tx_data, 0);
    chk("t6_in_rst_rdy", {req1_ready, req0_ready}, 0);
    rstv = 1'b0;
    step();
    chk("t6_after_ga", grant_active, 0);
    chk("t6_after_txv", tx_data_valid, 0);
    chk("t6_after_rdy", {req1_ready, req0_ready}, 0);
    txr = 1'b1;
    step();
    chk("t6_regrant", {grant_active, grant_id}, 2'b10);
    drain("t6", 30);
    chk("t6_idle", grant_active, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             nchk, nfail);
    $finish;
  end

endmodule
